// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/writeback sequencing.
// Optional MC_CTRL_PERF_EN adds cycle and retired-instruction counters.
module mc_ctrl (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [5:0] i_opcode,
  input  logic       i_mem_ready,
  output logic       o_mem_req,
  output logic       o_mem_we,
  output logic       o_iord,
  output logic       o_ir_we,
  output logic       o_pc_we,
  output logic       o_reg_we,
  output logic       o_alusrc,
  output logic [1:0] o_aluop,
  output logic       o_extop,
  output logic       o_jump,
  output logic       o_beq,
  output logic       o_bne,
  output logic       o_memtoreg,
  output logic       o_regdst,
  output logic       o_illegal,
  output logic [2:0] o_state
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] o_cycle_cnt,
  output logic [31:0] o_retire_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  state_t     state;
  logic [5:0] opcode;
  logic       run;
  logic       op_ok;
  logic       is_r, is_lw, is_sw, is_beq, is_bne;
  logic       is_j, is_addi, is_ori, is_br;
  logic       exec_ph;

  assign op_ok = i_opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ,
                                  OP_BNE, OP_J, OP_ADDI, OP_ORI};

  assign is_r    = (opcode == OP_R);
  assign is_lw   = (opcode == OP_LW);
  assign is_sw   = (opcode == OP_SW);
  assign is_beq  = (opcode == OP_BEQ);
  assign is_bne  = (opcode == OP_BNE);
  assign is_j    = (opcode == OP_J);
  assign is_addi = (opcode == OP_ADDI);
  assign is_ori  = (opcode == OP_ORI);
  assign is_br   = is_beq | is_bne | is_j;
  assign exec_ph = (state == S_EXEC) | (state == S_MEM) |
                   (state == S_WB);

  // run holds the FSM idle until the first clock edge after reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= S_FETCH;
      opcode <= '0;
      run    <= 1'b0;
    end else begin
      run <= 1'b1;
      if (run) begin
        unique case (state)
          S_FETCH:
            if (i_mem_ready) state <= S_DECODE;
          S_DECODE: begin
            opcode <= i_opcode;
            state  <= op_ok ? S_EXEC : S_TRAP;
          end
          S_EXEC:
            if (is_br)
              state <= S_FETCH;
            else if (is_lw | is_sw)
              state <= S_MEM;
            else
              state <= S_WB;
          S_MEM:
            if (i_mem_ready)
              state <= is_lw ? S_WB : S_FETCH;
          S_WB:
            state <= S_FETCH;
          S_TRAP:
            state <= S_TRAP;
          default:
            state <= S_TRAP;
        endcase
      end
    end
  end

  always_comb begin
    o_mem_req  = 1'b0;
    o_mem_we   = 1'b0;
    o_iord     = 1'b0;
    o_ir_we    = 1'b0;
    o_pc_we    = 1'b0;
    o_reg_we   = 1'b0;
    o_memtoreg = 1'b0;
    o_illegal  = 1'b0;
    o_state    = state;
    unique case (state)
      S_FETCH: begin
        o_mem_req = run;
        o_ir_we   = run & i_mem_ready;
      end
      S_EXEC:
        o_pc_we = is_br;
      S_MEM: begin
        o_mem_req = 1'b1;
        o_iord    = 1'b1;
        o_mem_we  = is_sw;
        o_pc_we   = is_sw & i_mem_ready;
      end
      S_WB: begin
        o_reg_we   = 1'b1;
        o_pc_we    = 1'b1;
        o_memtoreg = is_lw;
      end
      S_TRAP:
        o_illegal = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    o_aluop  = 2'b00;
    o_alusrc = 1'b0;
    o_extop  = 1'b0;
    o_regdst = 1'b0;
    o_jump   = 1'b0;
    o_beq    = 1'b0;
    o_bne    = 1'b0;
    if (exec_ph) begin
      unique case (1'b1)
        is_r: begin
          o_aluop  = 2'b10;
          o_regdst = 1'b1;
        end
        is_lw | is_sw | is_addi: begin
          o_alusrc = 1'b1;
          o_extop  = 1'b1;
        end
        is_beq | is_bne: begin
          o_aluop = 2'b01;
          o_extop = 1'b1;
          o_beq   = is_beq;
          o_bne   = is_bne;
        end
        is_j:
          o_jump = 1'b1;
        is_ori: begin
          o_aluop  = 2'b11;
          o_alusrc = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MC_CTRL_PERF_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cycle_cnt  <= '0;
      o_retire_cnt <= '0;
    end else if (run) begin
      o_cycle_cnt <= o_cycle_cnt + 32'd1;
      if (o_pc_we)
        o_retire_cnt <= o_retire_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have port i_clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port i_rst_n, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port i_opcode, input, 6, instruction[31:26] from instruction register.
REQ-004 SHALL have port i_mem_ready, input, 1, memory completes request this cycle.
REQ-005 SHALL have outputs o_mem_req (1), o_mem_we (1), o_iord (1); memory request, write strobe, address select (0 = PC, 1 = ALU result).
REQ-006 SHALL have outputs o_ir_we (1), o_pc_we (1), o_reg_we (1); IR load, PC update, register-file write.
REQ-007 SHALL have outputs to execute stage: o_alusrc (1), o_aluop (2), o_extop (1), o_jump (1), o_beq (1), o_bne (1).
REQ-008 SHALL have outputs o_memtoreg (1), o_regdst (1), o_illegal (1), o_state (3).

Function
REQ-009 SHALL implement FSM states FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, TRAP=7 on o_state.
REQ-010 FETCH: o_mem_req=1, o_iord=0; stay while i_mem_ready=0; on i_mem_ready=1 pulse o_ir_we=1 that cycle, then go DECODE.
REQ-011 DECODE: capture i_opcode into internal opcode register; go EXECUTE if supported, else TRAP.
REQ-012 Supported opcodes: R=000000, lw=100011, sw=101011, beq=000100, bne=000101, j=000010, addi=001000, ori=001101.
REQ-013 Execute controls SHALL be driven from the captured opcode in EXECUTE, MEMORY and WRITEBACK; 0 in other states.
REQ-014 Control table: R -> aluop=10, alusrc=0, regdst=1. lw/sw/addi -> aluop=00, alusrc=1, extop=1. beq/bne -> aluop=01, alusrc=0, extop=1, beq/bne=1. j -> jump=1. ori -> aluop=11, alusrc=1, extop=0.
REQ-015 EXECUTE: beq/bne/j assert o_pc_we=1 and go FETCH; lw/sw go MEMORY; R/addi/ori go WRITEBACK.
REQ-016 MEMORY: o_mem_req=1, o_iord=1, o_mem_we=1 for sw only; hold while i_mem_ready=0; on ready, lw goes WRITEBACK, sw asserts o_pc_we=1 and goes FETCH.
REQ-017 WRITEBACK: o_reg_we=1, o_pc_we=1, o_memtoreg=1 for lw only; go FETCH.
REQ-018 Latency with zero memory wait (i_mem_ready=1 on first request cycle): branch/jump 3 cycles, R/addi/ori/sw 4, lw 5; each wait cycle adds exactly 1.
REQ-019 o_pc_we, o_reg_we, o_ir_we SHALL each be high for exactly one cycle per instruction.
REQ-020 TRAP: o_illegal=1, all other strobes 0; sticky until reset.
REQ-021 i_mem_ready while o_mem_req=0 SHALL be ignored.
REQ-022 o_mem_req, o_mem_we, o_iord SHALL stay stable while waiting for i_mem_ready.

Reset
REQ-023 i_rst_n=0 SHALL immediately force FETCH, clear the opcode register, and drive every output to 0, including mid-wait and in TRAP.
REQ-024 First rising edge with i_rst_n=1 SHALL begin FETCH with o_mem_req=1.

Configuration
REQ-025 Macro MC_CTRL_PERF_EN defined: add outputs o_cycle_cnt (32) and o_retire_cnt (32).
REQ-026 o_cycle_cnt increments every cycle out of reset; o_retire_cnt increments on each o_pc_we; both wrap 0xFFFFFFFF -> 0 and reset to 0.
REQ-027 Macro undefined: neither port nor counter logic exists; all other behaviour is identical.

Verification
REQ-028 R-type, i_mem_ready tied 1 -> states 0,1,2,4,0; o_reg_we and o_pc_we high in cycle 4 only; aluop=10.
REQ-029 lw with 2 wait cycles in MEMORY -> o_mem_req=1, o_iord=1 for 3 cycles; total 7 cycles; o_memtoreg=1 in WRITEBACK.
REQ-030 beq -> states 0,1,2,0; o_beq=1, aluop=01 in EXECUTE; o_pc_we there; o_reg_we never asserted.
REQ-031 opcode 111111 -> TRAP after DECODE; o_illegal=1 held for 100 cycles; i_mem_ready pulses ignored.
REQ-032 i_rst_n low mid-MEMORY of sw -> outputs 0 same cycle, no o_pc_we; restart at FETCH.
REQ-033 With MC_CTRL_PERF_EN: 10 back-to-back j, zero wait -> o_retire_cnt=10, o_cycle_cnt=30.
